// File: rtl/uart_frame_sched.sv
// UART telemetry frame scheduler: snapshots game state on frame_tick and streams a
// 12-byte frame (sync, five tagged 16-bit words, XOR checksum) to a byte-wide UART.
`timescale 1ns/1ps
module uart_frame_sched #(
  parameter logic [7:0]  SYNC_BYTE = 8'hA5,
  parameter int unsigned TIMEOUT   = 20000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        frame_tick,
  input  logic [11:0] pl1_posx,
  input  logic [11:0] pl1_posy,
  input  logic [11:0] ball_posx,
  input  logic [11:0] ball_posy,
  input  logic [3:0]  pl1_score,
  input  logic [3:0]  pl2_score,
  input  logic        flag_point,
  input  logic        end_game,
  input  logic        tx_done,
  output logic [7:0]  tx_data,
  output logic        tx_start,
  output logic        busy,
  output logic        frame_done,
  output logic        tx_err,
  output logic [7:0]  drop_cnt
);

  localparam int unsigned       WAIT_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);
  localparam logic [3:0]        LAST_IDX  = 4'd11;

  typedef enum logic [1:0] {S_IDLE, S_SEND, S_WAIT} state_e;

  typedef struct packed {
    logic [11:0] pl1_posx;
    logic [11:0] pl1_posy;
    logic [11:0] ball_posx;
    logic [11:0] ball_posy;
    logic [3:0]  pl1_score;
    logic [3:0]  pl2_score;
    logic        flag_point;
    logic        end_game;
  } snap_t;

  state_e            state_q, state_d;
  snap_t             snap_q, snap_d;
  logic [3:0]        idx_q, idx_d;
  logic [WAIT_W-1:0] wait_q, wait_d, wait_inc;
  logic [7:0]        tx_data_q, tx_data_d;
  logic [7:0]        drop_q, drop_d;
  logic              frame_done_q, frame_done_d;
  logic              tx_err_q, tx_err_d;

  logic [0:4][15:0]  words;
  logic [7:0]        csum;
  logic [0:11][7:0]  frame;

  // Frame image derived purely from the snapshot; the status word keeps the two
  // flags left-justified in the payload with the scores in the low byte.
  always_comb begin
    words[0] = {4'h3, snap_q.pl1_posx};
    words[1] = {4'h4, snap_q.pl1_posy};
    words[2] = {4'h5, snap_q.ball_posx};
    words[3] = {4'h6, snap_q.ball_posy};
    words[4] = {4'h7, snap_q.end_game, snap_q.flag_point, 2'b00,
                snap_q.pl2_score, snap_q.pl1_score};
    csum = '0;
    for (int k = 0; k < 5; k++) begin
      csum = csum ^ words[k][15:8] ^ words[k][7:0];
    end
    frame = {SYNC_BYTE, words, csum};
  end

  assign wait_inc = wait_q + 1'b1;

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned; a missing default would infer a latch.
  always_comb begin
    state_d      = state_q;
    snap_d       = snap_q;
    idx_d        = idx_q;
    wait_d       = wait_q;
    tx_data_d    = tx_data_q;
    drop_d       = drop_q;
    frame_done_d = 1'b0;
    tx_err_d     = 1'b0;

    if (frame_tick && (state_q != S_IDLE) && (drop_q != 8'hFF)) begin
      drop_d = drop_q + 8'd1;
    end

    case (state_q)
      S_IDLE: begin
        if (frame_tick) begin
          state_d   = S_SEND;
          snap_d    = '{pl1_posx: pl1_posx, pl1_posy: pl1_posy,
                        ball_posx: ball_posx, ball_posy: ball_posy,
                        pl1_score: pl1_score, pl2_score: pl2_score,
                        flag_point: flag_point, end_game: end_game};
          idx_d     = 4'd0;
          tx_data_d = SYNC_BYTE;
        end
      end
      S_SEND: begin
        state_d = S_WAIT;
        wait_d  = '0;
      end
      S_WAIT: begin
        // tx_done wins over a timeout expiring in the same cycle.
        if (tx_done) begin
          if (idx_q != LAST_IDX) begin
            idx_d     = idx_q + 4'd1;
            tx_data_d = frame[idx_q + 4'd1];
            state_d   = S_SEND;
          end else begin
            state_d      = S_IDLE;
            frame_done_d = 1'b1;
          end
        end else if (wait_inc == WAIT_LAST) begin
          state_d  = S_IDLE;
          tx_err_d = 1'b1;
        end else begin
          wait_d = wait_inc;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state is updated with non-blocking assignments only, so
  // every register samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      // NOTE: the snapshot is ordinary flops, not a RAM, so it can and does
      // take a reset value like the rest of the state.
      snap_q       <= '0;
      idx_q        <= '0;
      wait_q       <= '0;
      tx_data_q    <= '0;
      drop_q       <= '0;
      frame_done_q <= 1'b0;
      tx_err_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      snap_q       <= snap_d;
      idx_q        <= idx_d;
      wait_q       <= wait_d;
      tx_data_q    <= tx_data_d;
      drop_q       <= drop_d;
      frame_done_q <= frame_done_d;
      tx_err_q     <= tx_err_d;
    end
  end

  assign tx_data    = tx_data_q;
  assign tx_start   = (state_q == S_SEND);
  assign busy       = (state_q != S_IDLE);
  assign frame_done = frame_done_q;
  assign tx_err     = tx_err_q;
  assign drop_cnt   = drop_q;

endmodule

// File: tb/tb_uart_frame_sched.sv
// Randomized self-checking bench for uart_frame_sched: the bench acts as the UART
// transmitter and compares every byte and status pulse against a frame-level model.
`timescale 1ns/1ps
module tb_uart_frame_sched;

  localparam int         TMO  = 16;
  localparam logic [7:0] SYNC = 8'hA5;

  typedef logic [7:0] frame_t [12];

  logic        clk = 1'b0;
  logic        rst, frame_tick, tx_done, flag_point, end_game;
  logic [11:0] pl1_posx, pl1_posy, ball_posx, ball_posy;
  logic [3:0]  pl1_score, pl2_score;
  logic [7:0]  tx_data, drop_cnt;
  logic        tx_start, busy, frame_done, tx_err;

  int total = 0;
  int bad = 0;
  int exp_drops = 0;
  int starts = 0;
  frame_t nom;

  uart_frame_sched #(.SYNC_BYTE(SYNC), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst), .frame_tick(frame_tick),
    .pl1_posx(pl1_posx), .pl1_posy(pl1_posy),
    .ball_posx(ball_posx), .ball_posy(ball_posy),
    .pl1_score(pl1_score), .pl2_score(pl2_score),
    .flag_point(flag_point), .end_game(end_game),
    .tx_done(tx_done), .tx_data(tx_data), .tx_start(tx_start),
    .busy(busy), .frame_done(frame_done), .tx_err(tx_err), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h (t=%0t)", tag, got, want, $time);
    end
  endtask

  // Advance to just after the next rising edge; outputs are sampled there.
  task automatic step();
    @(posedge clk);
    #1;
    if (tx_start === 1'b1) starts++;
  endtask

  task automatic tick_busy();
    frame_tick = 1'b1;
    if (exp_drops < 255) exp_drops++;
  endtask

  task automatic set_inputs(input logic [11:0] px, py, bx, by,
                            input logic [3:0] s1, s2, input logic fp, eg);
    pl1_posx = px; pl1_posy = py; ball_posx = bx; ball_posy = by;
    pl1_score = s1; pl2_score = s2; flag_point = fp; end_game = eg;
  endtask

  task automatic rand_inputs();
    set_inputs(12'($urandom), 12'($urandom), 12'($urandom), 12'($urandom),
               4'($urandom), 4'($urandom), 1'($urandom), 1'($urandom));
  endtask

  // Frame built from the wire-format rules using integer arithmetic.
  function automatic frame_t model_frame();
    int     w [5];
    int     x;
    frame_t f;
    w[0] = 'h3000 + pl1_posx;
    w[1] = 'h4000 + pl1_posy;
    w[2] = 'h5000 + ball_posx;
    w[3] = 'h6000 + ball_posy;
    w[4] = 'h7000 + end_game * 2048 + flag_point * 1024 + pl2_score * 16 + pl1_score;
    x = 0;
    f[0] = SYNC;
    for (int k = 0; k < 5; k++) begin
      f[1 + 2 * k] = 8'(w[k] / 256);
      f[2 + 2 * k] = 8'(w[k] % 256);
      x = x ^ (w[k] / 256) ^ (w[k] % 256);
    end
    f[11] = 8'(x);
    return f;
  endfunction

  // One frame starting from an idle cycle. dly=0 picks a random tx_done delay
  // per byte. abort_kind 1 withholds tx_done at abort_idx, 2 resets mid-byte.
  task automatic run_frame(input frame_t exp, input int dly, input int tick_pct,
                           input logic [11:0] tick_mask, input bit final_tick,
                           input bit zero_inputs, input int abort_idx, input int abort_kind);
    int d;
    check("idle_before", 32'(busy), 32'd0);
    starts = 0;
    frame_tick = 1'b1;
    for (int b = 0; b < 12; b++) begin
      step(); frame_tick = 1'b0; tx_done = 1'b0;
      check("send_start", 32'(tx_start), 32'd1);
      check("send_data", 32'(tx_data), 32'(exp[b]));
      if (b == 0) begin
        check("send_busy", 32'(busy), 32'd1);
        check("send_err", 32'(tx_err), 32'd0);
        check("send_fdone", 32'(frame_done), 32'd0);
        if (zero_inputs) set_inputs('0, '0, '0, '0, '0, '0, 1'b0, 1'b0);
      end
      if (tick_mask[b] || ($urandom_range(0, 99) < tick_pct)) tick_busy();
      if ($urandom_range(0, 3) == 0) tx_done = 1'b1;
      if (abort_kind == 1 && b == abort_idx) begin
        for (int k = 1; k <= TMO; k++) begin
          step(); frame_tick = 1'b0; tx_done = 1'b0;
          if (k < TMO) begin
            check("stall_err", 32'(tx_err), 32'd0);
            check("stall_busy", 32'(busy), 32'd1);
            if ($urandom_range(0, 99) < tick_pct) tick_busy();
          end else begin
            check("tmo_err", 32'(tx_err), 32'd1);
            check("tmo_busy", 32'(busy), 32'd0);
            check("tmo_fdone", 32'(frame_done), 32'd0);
            check("tmo_drops", 32'(drop_cnt), 32'(exp_drops));
          end
        end
        return;
      end
      d = (dly > 0) ? dly : $urandom_range(1, TMO - 1);
      for (int k = 1; k <= d; k++) begin
        step(); frame_tick = 1'b0; tx_done = 1'b0;
        check("wait_start", 32'(tx_start), 32'd0);
        check("wait_data", 32'(tx_data), 32'(exp[b]));
        check("wait_fdone", 32'(frame_done), 32'd0);
        check("wait_err", 32'(tx_err), 32'd0);
        if (abort_kind == 2 && b == abort_idx && k == 3) begin
          rst = 1'b1;
          step();
          exp_drops = 0;
          check("rst_data", 32'(tx_data), 32'd0);
          check("rst_start", 32'(tx_start), 32'd0);
          check("rst_busy", 32'(busy), 32'd0);
          check("rst_fdone", 32'(frame_done), 32'd0);
          check("rst_err", 32'(tx_err), 32'd0);
          check("rst_drops", 32'(drop_cnt), 32'd0);
          rst = 1'b0;
          tx_done = 1'b1;
          step(); tx_done = 1'b0;
          check("stray_start", 32'(tx_start), 32'd0);
          check("stray_busy", 32'(busy), 32'd0);
          step();
          check("stray_start2", 32'(tx_start), 32'd0);
          return;
        end
        if (k == d) begin
          tx_done = 1'b1;
          if (b == 11 && final_tick) tick_busy();
        end else if ($urandom_range(0, 99) < tick_pct) begin
          tick_busy();
        end
      end
    end
    step(); frame_tick = 1'b0; tx_done = 1'b0;
    check("frame_done", 32'(frame_done), 32'd1);
    check("end_busy", 32'(busy), 32'd0);
    check("end_err", 32'(tx_err), 32'd0);
    check("start_count", 32'(starts), 32'd12);
    check("drops", 32'(drop_cnt), 32'(exp_drops));
  endtask

  initial begin
    nom = '{8'hA5, 8'h31, 8'h23, 8'h44, 8'h56, 8'h57, 8'h89, 8'h60, 8'hAB, 8'h78, 8'h25, 8'h48};
    rst = 1'b1; frame_tick = 1'b1; tx_done = 1'b1;
    set_inputs(12'hFFF, 12'hFFF, 12'hFFF, 12'hFFF, 4'hF, 4'hF, 1'b1, 1'b1);
    repeat (3) step();
    check("reset_data", 32'(tx_data), 32'd0);
    check("reset_start", 32'(tx_start), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_fdone", 32'(frame_done), 32'd0);
    check("reset_err", 32'(tx_err), 32'd0);
    check("reset_drops", 32'(drop_cnt), 32'd0);
    rst = 1'b0; frame_tick = 1'b0;
    step(); tx_done = 1'b0;
    check("idle_txdone_start", 32'(tx_start), 32'd0);
    check("idle_txdone_busy", 32'(busy), 32'd0);

    // Nominal frame, then a back-to-back frame whose inputs are cleared after capture.
    set_inputs(12'h123, 12'h456, 12'h789, 12'h0AB, 4'd5, 4'd2, 1'b0, 1'b1);
    run_frame(nom, 10, 0, 12'h000, 1'b0, 1'b0, -1, 0);
    run_frame(nom, 10, 0, 12'h000, 1'b0, 1'b1, -1, 0);

    // Three dropped ticks, one coinciding with the final tx_done.
    set_inputs(12'h123, 12'h456, 12'h789, 12'h0AB, 4'd5, 4'd2, 1'b0, 1'b1);
    run_frame(nom, 10, 0, 12'h084, 1'b1, 1'b0, -1, 0);
    check("drop_three", 32'(drop_cnt), 32'd3);
    step();

    for (int i = 0; i < 8; i++) begin
      rand_inputs();
      run_frame(model_frame(), 0, 20, 12'h000, 1'($urandom), 1'b0, -1, 0);
      if ($urandom_range(0, 1) == 1) step();
    end

    // tx_done on the last cycle before expiry still counts.
    rand_inputs();
    run_frame(model_frame(), TMO - 1, 0, 12'h000, 1'b0, 1'b0, -1, 0);

    // Timeout after byte 4, then a fresh frame.
    rand_inputs();
    run_frame(model_frame(), 0, 10, 12'h000, 1'b0, 1'b0, 4, 1);
    step();
    check("post_tmo_err", 32'(tx_err), 32'd0);
    rand_inputs();
    run_frame(model_frame(), 0, 0, 12'h000, 1'b0, 1'b0, -1, 0);

    // Saturate the drop counter with ticks on every busy cycle.
    rand_inputs();
    run_frame(model_frame(), TMO - 1, 100, 12'hFFF, 1'b1, 1'b0, -1, 0);
    rand_inputs();
    run_frame(model_frame(), TMO - 1, 100, 12'hFFF, 1'b1, 1'b0, -1, 0);
    check("drop_sat", 32'(drop_cnt), 32'd255);

    // Reset in the middle of byte 5, then a clean frame.
    rand_inputs();
    run_frame(model_frame(), 10, 0, 12'h000, 1'b0, 1'b0, 5, 2);
    rand_inputs();
    run_frame(model_frame(), 0, 0, 12'h000, 1'b0, 1'b0, -1, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
